// File: rtl/spi_slave_tx_fifo.sv
// SPI slave transmit path: TX FIFO with valid/ready push, synchronised SCK/SSEL,
// configurable word width, CPOL/CPHA and bit order. MISO is always driven.
module spi_slave_tx_fifo #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           FIFO_DEPTH = 4,
    parameter bit                    CPOL       = 1'b0,
    parameter bit                    CPHA       = 1'b0,
    parameter bit                    LSB_FIRST  = 1'b0,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = '1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          SCK,
    input  logic                          SSEL,
    output logic                          MISO,
    input  logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          word_sent,
    output logic                          underrun
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned LW   = AW + 1;
    localparam int unsigned CW   = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t                  state;
    logic [2:0]              sck_sync;
    logic [2:0]              ssel_sync;
    logic [DATA_WIDTH-1:0]   shreg;
    logic [CW-1:0]           bitcnt;

    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [LW-1:0]           count;

    logic                    sck_lead;
    logic                    sck_trail;
    logic                    sample_edge;
    logic                    shift_edge;
    logic                    ssel_fall;
    logic                    ssel_rise;
    logic                    word_done;
    logic                    load;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    do_push;
    logic                    do_pop;
    logic [DATA_WIDTH-1:0]   load_word;
    logic [DATA_WIDTH-1:0]   shifted;

    // Edge detection on the synchronised SCK/SSEL (stages [2:1])
    assign sck_lead    = (sck_sync[1] != CPOL) && (sck_sync[2] == CPOL);
    assign sck_trail   = (sck_sync[1] == CPOL) && (sck_sync[2] != CPOL);
    assign sample_edge = CPHA ? sck_trail : sck_lead;
    assign shift_edge  = CPHA ? sck_lead  : sck_trail;
    assign ssel_fall   = ~ssel_sync[1] &  ssel_sync[2];
    assign ssel_rise   =  ssel_sync[1] & ~ssel_sync[2];

    // Word boundary: a new word is loaded at frame start and after the last sample edge
    assign word_done  = (state == S_ACTIVE) && !ssel_rise && sample_edge && (bitcnt == LAST_BIT);
    assign load       = ((state == S_IDLE) && ssel_fall) || word_done;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == LW'(FIFO_DEPTH));
    assign tx_ready   = ~fifo_full;
    assign do_push    = tx_valid && !fifo_full;
    assign do_pop     = load && !fifo_empty;
    assign load_word  = fifo_empty ? IDLE_WORD : mem[rd_ptr];
    assign fifo_level = count;

    // Shift toward the output bit, refilling the vacated end with 1
    assign shifted = LSB_FIRST ? {1'b1, shreg[DATA_WIDTH-1:1]}
                               : {shreg[DATA_WIDTH-2:0], 1'b1};
    assign MISO    = LSB_FIRST ? shreg[0] : shreg[DATA_WIDTH-1];

    // FIFO storage; no reset needed, occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; a full FIFO refuses pushes even when popping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Synchronisers, frame FSM, shift register and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= {3{CPOL}};
            ssel_sync <= 3'b111;
            state     <= S_IDLE;
            shreg     <= IDLE_WORD;
            bitcnt    <= '0;
            word_sent <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[1:0], SCK};
            ssel_sync <= {ssel_sync[1:0], SSEL};
            word_sent <= 1'b0;
            underrun  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ssel_fall) begin
                        state    <= S_ACTIVE;
                        bitcnt   <= '0;
                        shreg    <= load_word;
                        underrun <= fifo_empty;
                    end
                end
                S_ACTIVE: begin
                    if (ssel_rise) begin
                        state  <= S_IDLE;
                        bitcnt <= '0;
                        shreg  <= IDLE_WORD;
                    end else if (sample_edge) begin
                        if (bitcnt == LAST_BIT) begin
                            bitcnt    <= '0;
                            word_sent <= 1'b1;
                            shreg     <= load_word;
                            underrun  <= fifo_empty;
                        end else begin
                            bitcnt <= bitcnt + CW'(1);
                        end
                    end else if (shift_edge && (bitcnt != '0)) begin
                        shreg <= shifted;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_tx_fifo.sv
// Directed bench for spi_slave_tx_fifo: a mode-0 MSB-first instance and a
// CPOL=1/CPHA=1/LSB-first instance, driven by a simple SPI master model.
module tb_spi_slave_tx_fifo;

    logic        clk;
    logic        rst;

    logic        sck_a, ssel_a, miso_a, tx_valid_a, tx_ready_a, word_sent_a, underrun_a;
    logic [7:0]  tx_data_a;
    logic [2:0]  level_a;

    logic        sck_b, ssel_b, miso_b, tx_valid_b, tx_ready_b, word_sent_b, underrun_b;
    logic [7:0]  tx_data_b;
    logic [2:0]  level_b;

    int          errors;
    int          checks;
    int          ws_a, ur_a, ws_b, ur_b;
    int          s_ws, s_ur;
    logic [31:0] rx;

    spi_slave_tx_fifo #(
        .DATA_WIDTH(8), .FIFO_DEPTH(4), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b0)
    ) u_dut_a (
        .clk(clk), .rst(rst), .SCK(sck_a), .SSEL(ssel_a), .MISO(miso_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .fifo_level(level_a), .word_sent(word_sent_a), .underrun(underrun_a)
    );

    spi_slave_tx_fifo #(
        .DATA_WIDTH(8), .FIFO_DEPTH(4), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .SCK(sck_b), .SSEL(ssel_b), .MISO(miso_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .fifo_level(level_b), .word_sent(word_sent_b), .underrun(underrun_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled away from the active edge
    always @(negedge clk) begin
        if (word_sent_a === 1'b1) ws_a++;
        if (underrun_a  === 1'b1) ur_a++;
        if (word_sent_b === 1'b1) ws_b++;
        if (underrun_b  === 1'b1) ur_b++;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_a(input logic [7:0] d);
        tx_data_a  = d;
        tx_valid_a = 1'b1;
        @(negedge clk);
        tx_valid_a = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] d);
        tx_data_b  = d;
        tx_valid_b = 1'b1;
        @(negedge clk);
        tx_valid_b = 1'b0;
    endtask

    task automatic sel_a(input logic v);
        wait_clk(8);
        ssel_a = v;
        wait_clk(8);
    endtask

    task automatic sel_b(input logic v);
        wait_clk(8);
        ssel_b = v;
        wait_clk(8);
    endtask

    // Mode 0 master: sample MISO at each rising edge, SCK idles low
    task automatic shift_a(input int n, output logic [31:0] r);
        r = '0;
        for (int i = 0; i < n; i++) begin
            wait_clk(8);
            r = {r[30:0], miso_a};
            sck_a = 1'b1;
            wait_clk(8);
            sck_a = 1'b0;
        end
    endtask

    // Mode 3 master: falling edge leads, sample MISO at each rising edge
    task automatic shift_b(input int n, output logic [31:0] r);
        r = '0;
        for (int i = 0; i < n; i++) begin
            wait_clk(8);
            sck_b = 1'b0;
            wait_clk(8);
            r = {r[30:0], miso_b};
            sck_b = 1'b1;
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        ws_a = 0; ur_a = 0; ws_b = 0; ur_b = 0;
        rst = 1'b1;
        sck_a = 1'b0; ssel_a = 1'b1; tx_valid_a = 1'b0; tx_data_a = '0;
        sck_b = 1'b1; ssel_b = 1'b1; tx_valid_b = 1'b0; tx_data_b = '0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(1);

        // Reset state
        check("rst_level_a",    32'(level_a),     32'd0);
        check("rst_ready_a",    32'(tx_ready_a),  32'd1);
        check("rst_miso_a",     32'(miso_a),      32'd1);
        check("rst_wsent_a",    32'(word_sent_a), 32'd0);
        check("rst_underrun_a", 32'(underrun_a),  32'd0);
        check("rst_miso_b",     32'(miso_b),      32'd1);
        check("rst_level_b",    32'(level_b),     32'd0);

        // Mode 0 two-word frame; a third word keeps the end-of-frame load fed
        push_a(8'hA5);
        push_a(8'h3C);
        push_a(8'h5A);
        check("m0_level_pre", 32'(level_a), 32'd3);
        s_ws = ws_a; s_ur = ur_a;
        sel_a(1'b0);
        shift_a(16, rx);
        sel_a(1'b1);
        check("m0_data",      rx,                32'h0000A53C);
        check("m0_wsent",     32'(ws_a - s_ws),  32'd2);
        check("m0_underrun",  32'(ur_a - s_ur),  32'd0);
        check("m0_level_end", 32'(level_a),      32'd0);

        // CPOL=1 CPHA=1 LSB-first: 0x81 arrives as 1,0,0,0,0,0,0,1
        push_b(8'h81);
        s_ws = ws_b;
        sel_b(1'b0);
        shift_b(8, rx);
        sel_b(1'b1);
        check("m3_data",     rx,               32'h00000081);
        check("m3_wsent",    32'(ws_b - s_ws), 32'd1);
        check("m3_underrun", 32'(ur_b),        32'd1);

        // Underrun at frame start; a word pushed mid-word feeds the next load
        s_ws = ws_a; s_ur = ur_a;
        sel_a(1'b0);
        push_a(8'h12);
        shift_a(8, rx);
        sel_a(1'b1);
        check("ur_data",     rx,               32'h000000FF);
        check("ur_underrun", 32'(ur_a - s_ur), 32'd1);
        check("ur_wsent",    32'(ws_a - s_ws), 32'd1);
        check("ur_level",    32'(level_a),     32'd0);

        // Abort after 3 bits of 0xF0; next frame carries 0x0F
        push_a(8'hF0);
        push_a(8'h0F);
        s_ws = ws_a;
        sel_a(1'b0);
        shift_a(3, rx);
        sel_a(1'b1);
        check("ab_partial", rx,               32'h00000007);
        check("ab_wsent",   32'(ws_a - s_ws), 32'd0);
        check("ab_level",   32'(level_a),     32'd1);
        s_ws = ws_a;
        sel_a(1'b0);
        shift_a(8, rx);
        sel_a(1'b1);
        check("ab_next_data",  rx,               32'h0000000F);
        check("ab_next_wsent", 32'(ws_a - s_ws), 32'd1);

        // Full FIFO refuses the fifth push
        push_a(8'h11);
        push_a(8'h22);
        push_a(8'h33);
        push_a(8'h44);
        check("full_ready", 32'(tx_ready_a), 32'd0);
        check("full_level", 32'(level_a),    32'd4);
        push_a(8'h55);
        check("full_refused_level", 32'(level_a), 32'd4);

        // Reset mid-word with SSEL low
        sel_a(1'b0);
        check("mid_level", 32'(level_a), 32'd3);
        shift_a(3, rx);
        s_ur = ur_a;
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        check("mr_level",    32'(level_a),     32'd0);
        check("mr_ready",    32'(tx_ready_a),  32'd1);
        check("mr_miso",     32'(miso_a),      32'd1);
        check("mr_underrun", 32'(underrun_a),  32'd0);
        check("mr_wsent",    32'(word_sent_a), 32'd0);
        wait_clk(8);
        check("mr_restart_underrun", 32'(ur_a - s_ur), 32'd1);
        shift_a(8, rx);
        sel_a(1'b1);
        check("mr_restart_data", rx, 32'h000000FF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
